wb_arbiter2: RTL and testbench

//  Two-master, one-slave arbiter for the pipelined 32-bit Wishbone bus. Master A is the

---
 rtl/wb_arbiter2_if.sv | 32 +++
 rtl/wb_arbiter2.sv | 150 +++++++++++++++
 tb/tb_wb_arbiter2.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter2_if.sv
// Pipelined 32-bit Wishbone link between one bus master and one bus slave.
// Latency: none, this is a bundle of wires.
// Backpressure: the slave throttles the master through stall; completion is ack or err.
interface wb_arbiter2_if #(
  parameter int AW = 30
);
  // Request direction, master to slave
  logic          cyc;
  logic          stb;
  logic          we;
  logic [AW-1:0] addr;
  logic [31:0]   wr_dat;
  logic [3:0]    sel;

  // Response direction, slave to master
  logic          stall;
  logic          ack;
  logic          err;
  logic [31:0]   rd_dat;

  // The master side drives the request and consumes the response
  modport master (
    output cyc, stb, we, addr, wr_dat, sel,
    input  stall, ack, err, rd_dat
  );

  // The slave side consumes the request and drives the response
  modport slave (
    input  cyc, stb, we, addr, wr_dat, sel,
    output stall, ack, err, rd_dat
  );
endinterface

// File: rtl/wb_arbiter2.sv
// Two-master to one-slave Wishbone arbiter with round-robin grant and a bus watchdog.
// Latency: a request seen in cycle N is granted in cycle N+1; once granted, the path is combinational.
// Backpressure: the non-owner is held stalled; the owner sees the slave's stall directly.
module wb_arbiter2 #(
  parameter int AW      = 30,
  parameter int TIMEOUT = 255
) (
  input  logic          i_clk,
  input  logic          i_reset,
  wb_arbiter2_if.slave  a_bus,
  wb_arbiter2_if.slave  b_bus,
  wb_arbiter2_if.master wb_bus
);

  // The watchdog never counts past TIMEOUT-1, so this width always holds it.
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2,
    ABORT = 2'd3
  } state_t;

  state_t        state;
  // Last master granted. It also names the owner while in GNT_x or ABORT,
  // because it is updated on every entry to GNT_x.
  logic          last_b;
  logic [CW-1:0] wd_cnt;

  logic          owner_cyc;
  logic          granted;
  logic          grant_cyc;
  logic          wb_busy;
  logic          timeout_hit;
  logic [AW-1:0] addr_mux;

  // Cycle line of the current (or aborted) owner.
  always_comb begin
    owner_cyc = last_b ? b_bus.cyc : a_bus.cyc;
  end

  // Slave-side busy: a granted cycle that has not been answered this cycle.
  // The timeout fires in the busy cycle that would take the count to TIMEOUT,
  // so the owner sees the error in that same cycle and the bus drops on the next.
  always_comb begin
    granted     = (state == GNT_A) || (state == GNT_B);
    grant_cyc   = granted && owner_cyc;
    wb_busy     = grant_cyc && !wb_bus.ack && !wb_bus.err;
    timeout_hit = wb_busy && (wd_cnt == CW'(TIMEOUT - 1));
  end

  // Route the owner's request to the slave and the slave's response back to the owner;
  // everyone else sees a stalled, silent bus.
  always_comb begin
    wb_bus.cyc    = 1'b0;
    wb_bus.stb    = 1'b0;
    wb_bus.we     = 1'b0;
    wb_bus.wr_dat = 32'h0;
    wb_bus.sel    = 4'h0;
    addr_mux      = '0;

    a_bus.stall   = 1'b1;
    a_bus.ack     = 1'b0;
    a_bus.err     = 1'b0;
    b_bus.stall   = 1'b1;
    b_bus.ack     = 1'b0;
    b_bus.err     = 1'b0;

    // Read data fans out unconditionally; it is qualified by ack at the master.
    a_bus.rd_dat  = wb_bus.rd_dat;
    b_bus.rd_dat  = wb_bus.rd_dat;

    case (state)
      GNT_A: begin
        wb_bus.cyc    = a_bus.cyc;
        wb_bus.stb    = a_bus.stb;
        wb_bus.we     = a_bus.we;
        wb_bus.wr_dat = a_bus.wr_dat;
        wb_bus.sel    = a_bus.sel;
        addr_mux      = a_bus.addr;
        a_bus.stall   = wb_bus.stall;
        a_bus.ack     = wb_bus.ack;
        a_bus.err     = wb_bus.err || timeout_hit;
      end
      GNT_B: begin
        wb_bus.cyc    = b_bus.cyc;
        wb_bus.stb    = b_bus.stb;
        wb_bus.we     = b_bus.we;
        wb_bus.wr_dat = b_bus.wr_dat;
        wb_bus.sel    = b_bus.sel;
        addr_mux      = b_bus.addr;
        b_bus.stall   = wb_bus.stall;
        b_bus.ack     = wb_bus.ack;
        b_bus.err     = wb_bus.err || timeout_hit;
      end
      default: begin
        // IDLE and ABORT: slave sees no cycle, late slave responses are dropped.
      end
    endcase

    wb_bus.addr = addr_mux;
  end

  // Grant state machine, round-robin pointer and watchdog counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state  <= IDLE;
      last_b <= 1'b1;
      wd_cnt <= '0;
    end else begin
      if (!wb_busy || timeout_hit) begin
        wd_cnt <= '0;
      end else begin
        wd_cnt <= wd_cnt + CW'(1);
      end

      case (state)
        IDLE: begin
          // Decision uses only registered state plus this cycle's requests,
          // so the grant always appears one cycle after the request.
          if (a_bus.cyc && (!b_bus.cyc || last_b)) begin
            state  <= GNT_A;
            last_b <= 1'b0;
          end else if (b_bus.cyc) begin
            state  <= GNT_B;
            last_b <= 1'b1;
          end
        end
        GNT_A, GNT_B: begin
          // Always pass through IDLE between grants, even with the other master waiting.
          if (!owner_cyc) begin
            state <= IDLE;
          end else if (timeout_hit) begin
            state <= ABORT;
          end
        end
        ABORT: begin
          if (!owner_cyc) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2: a cycle-by-cycle vector table plus
// hand-written sequences for the watchdog abort and reset in mid-cycle.
module tb_wb_arbiter2;

  localparam int AW      = 30;
  localparam int TIMEOUT = 8;
  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] CD = 32'h12345678;

  logic i_clk = 1'b0;
  logic i_reset;

  always #5 i_clk = ~i_clk;

  wb_arbiter2_if #(.AW(AW)) ma ();
  wb_arbiter2_if #(.AW(AW)) mb ();
  wb_arbiter2_if #(.AW(AW)) sl ();

  wb_arbiter2 #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .a_bus  (ma),
    .b_bus  (mb),
    .wb_bus (sl)
  );

  // ctl = {rst, a_cyc, a_stb, a_we, b_cyc, b_stb, b_we}
  // sl  = {slave stall, ack, err}; ew = {wb cyc, stb, we}; ar/br = {stall, ack, err}
  typedef struct {
    string       name;
    logic [6:0]  ctl;
    logic [29:0] aa;
    logic [29:0] ba;
    logic [2:0]  sl;
    logic [31:0] sd;
    logic [2:0]  ew;
    logic [29:0] ea;
    logic [31:0] ed;
    logic [3:0]  es;
    logic [2:0]  ar;
    logic [2:0]  br;
  } vec_t;

  vec_t tbl[$];
  int checks   = 0;
  int failures = 0;

  function automatic vec_t v(string n, logic [6:0] ctl, logic [29:0] aa, logic [29:0] ba,
                             logic [2:0] s, logic [31:0] sd, logic [2:0] ew, logic [29:0] ea,
                             logic [31:0] ed, logic [3:0] es, logic [2:0] ar, logic [2:0] br);
    vec_t t;
    t.name = n; t.ctl = ctl; t.aa = aa; t.ba = ba; t.sl = s; t.sd = sd;
    t.ew = ew; t.ea = ea; t.ed = ed; t.es = es; t.ar = ar; t.br = br;
    return t;
  endfunction

  // Arbiter idle or aborting: no slave cycle, both masters stalled.
  function automatic vec_t idle(string n, logic [6:0] ctl, logic [29:0] aa, logic [29:0] ba,
                                logic [2:0] s, logic [31:0] sd);
    return v(n, ctl, aa, ba, s, sd, 3'b000, 30'h0, 32'h0, 4'h0, 3'b100, 3'b100);
  endfunction

  task automatic chkw(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  task automatic chkb(string n, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", n, act, exp);
    end
  endtask

  task automatic drive(logic [6:0] ctl, logic [29:0] aa, logic [29:0] ba, logic [2:0] s,
                       logic [31:0] sd);
    i_reset   = ctl[6];
    ma.cyc    = ctl[5];
    ma.stb    = ctl[4];
    ma.we     = ctl[3];
    ma.addr   = aa;
    ma.wr_dat = 32'hAAAA0000 | 32'(aa);
    ma.sel    = 4'hF;
    mb.cyc    = ctl[2];
    mb.stb    = ctl[1];
    mb.we     = ctl[0];
    mb.addr   = ba;
    mb.wr_dat = 32'hBBBB0000 | 32'(ba);
    mb.sel    = 4'h3;
    sl.stall  = s[2];
    sl.ack    = s[1];
    sl.err    = s[0];
    sl.rd_dat = sd;
  endtask

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_row(vec_t t);
    chkw({t.name, ".wb_cyc_stb_we"}, 32'({sl.cyc, sl.stb, sl.we}), 32'(t.ew));
    chkw({t.name, ".wb_addr"}, 32'(sl.addr), 32'(t.ea));
    chkw({t.name, ".wb_wdat"}, sl.wr_dat, t.ed);
    chkw({t.name, ".wb_sel"}, 32'(sl.sel), 32'(t.es));
    chkw({t.name, ".a_stall_ack_err"}, 32'({ma.stall, ma.ack, ma.err}), 32'(t.ar));
    chkw({t.name, ".b_stall_ack_err"}, 32'({mb.stall, mb.ack, mb.err}), 32'(t.br));
    chkw({t.name, ".a_rdat"}, ma.rd_dat, t.sd);
    chkw({t.name, ".b_rdat"}, mb.rd_dat, t.sd);
  endtask

  initial begin
    // A-only read, slave acks two cycles after the strobe
    tbl.push_back(idle("rst_idle",   7'b0_000_000, 30'h40, 30'h0, 3'b000, DB));
    tbl.push_back(idle("a_req",      7'b0_110_000, 30'h40, 30'h0, 3'b000, DB));
    tbl.push_back(v("a_gnt",         7'b0_110_000, 30'h40, 30'h0, 3'b000, DB,
                    3'b110, 30'h40, 32'hAAAA0040, 4'hF, 3'b000, 3'b100));
    tbl.push_back(v("a_wait",        7'b0_100_000, 30'h40, 30'h0, 3'b000, DB,
                    3'b100, 30'h40, 32'hAAAA0040, 4'hF, 3'b000, 3'b100));
    tbl.push_back(v("a_ack",         7'b0_100_000, 30'h40, 30'h0, 3'b010, DB,
                    3'b100, 30'h40, 32'hAAAA0040, 4'hF, 3'b010, 3'b100));
    tbl.push_back(v("a_drop",        7'b0_000_000, 30'h40, 30'h0, 3'b000, DB,
                    3'b000, 30'h40, 32'hAAAA0040, 4'hF, 3'b000, 3'b100));
    tbl.push_back(idle("a_idle",     7'b0_000_000, 30'h40, 30'h0, 3'b000, DB));
    // Reset, then A and B request together: A first, one IDLE cycle, then B
    tbl.push_back(idle("rst_row",    7'b1_000_000, 30'h40, 30'h0, 3'b000, DB));
    tbl.push_back(idle("both_req",   7'b0_110_110, 30'h44, 30'h100, 3'b000, DB));
    tbl.push_back(v("both_gnt_a",    7'b0_110_110, 30'h44, 30'h100, 3'b000, DB,
                    3'b110, 30'h44, 32'hAAAA0044, 4'hF, 3'b000, 3'b100));
    tbl.push_back(v("a_ack2",        7'b0_100_110, 30'h44, 30'h100, 3'b010, DB,
                    3'b100, 30'h44, 32'hAAAA0044, 4'hF, 3'b010, 3'b100));
    tbl.push_back(v("a_drop2",       7'b0_000_111, 30'h44, 30'h100, 3'b000, DB,
                    3'b000, 30'h44, 32'hAAAA0044, 4'hF, 3'b000, 3'b100));
    tbl.push_back(idle("gap_ab",     7'b0_000_111, 30'h44, 30'h100, 3'b000, DB));
    // B: three pipelined writes, 2nd stalled once, A waiting throughout
    tbl.push_back(v("b_wr1",         7'b0_110_111, 30'h48, 30'h100, 3'b000, CD,
                    3'b111, 30'h100, 32'hBBBB0100, 4'h3, 3'b100, 3'b000));
    tbl.push_back(v("b_wr2_stall",   7'b0_110_111, 30'h48, 30'h101, 3'b100, CD,
                    3'b111, 30'h101, 32'hBBBB0101, 4'h3, 3'b100, 3'b100));
    tbl.push_back(v("b_wr2",         7'b0_110_111, 30'h48, 30'h101, 3'b010, CD,
                    3'b111, 30'h101, 32'hBBBB0101, 4'h3, 3'b100, 3'b010));
    tbl.push_back(v("b_wr3",         7'b0_110_111, 30'h48, 30'h102, 3'b010, CD,
                    3'b111, 30'h102, 32'hBBBB0102, 4'h3, 3'b100, 3'b010));
    tbl.push_back(v("b_last_ack",    7'b0_110_100, 30'h48, 30'h102, 3'b010, CD,
                    3'b100, 30'h102, 32'hBBBB0102, 4'h3, 3'b100, 3'b010));
    tbl.push_back(v("b_drop",        7'b0_110_000, 30'h48, 30'h102, 3'b000, CD,
                    3'b000, 30'h102, 32'hBBBB0102, 4'h3, 3'b100, 3'b000));
    tbl.push_back(idle("gap_ba",     7'b0_110_000, 30'h48, 30'h102, 3'b000, DB));
    tbl.push_back(v("a_after_b",     7'b0_110_000, 30'h48, 30'h102, 3'b000, DB,
                    3'b110, 30'h48, 32'hAAAA0048, 4'hF, 3'b000, 3'b100));
    tbl.push_back(v("a_drop3",       7'b0_000_000, 30'h48, 30'h102, 3'b000, DB,
                    3'b000, 30'h48, 32'hAAAA0048, 4'hF, 3'b000, 3'b100));
    tbl.push_back(idle("idle3",      7'b0_000_000, 30'h48, 30'h102, 3'b000, DB));
    // B read answered with a slave error; grant held until B drops cyc
    tbl.push_back(idle("b_rd_req",   7'b0_000_110, 30'h4C, 30'h200, 3'b000, DB));
    tbl.push_back(v("b_rd_gnt",      7'b0_000_110, 30'h4C, 30'h200, 3'b000, DB,
                    3'b110, 30'h200, 32'hBBBB0200, 4'h3, 3'b100, 3'b000));
    tbl.push_back(v("b_err",         7'b0_000_100, 30'h4C, 30'h200, 3'b001, DB,
                    3'b100, 30'h200, 32'hBBBB0200, 4'h3, 3'b100, 3'b001));
    tbl.push_back(v("b_hold",        7'b0_110_100, 30'h4C, 30'h200, 3'b000, DB,
                    3'b100, 30'h200, 32'hBBBB0200, 4'h3, 3'b100, 3'b000));
    tbl.push_back(v("b_drop_err",    7'b0_110_000, 30'h4C, 30'h200, 3'b000, DB,
                    3'b000, 30'h200, 32'hBBBB0200, 4'h3, 3'b100, 3'b000));
    tbl.push_back(idle("gap_ba2",    7'b0_110_000, 30'h4C, 30'h200, 3'b000, DB));
    tbl.push_back(v("a_after_err",   7'b0_110_000, 30'h4C, 30'h200, 3'b000, DB,
                    3'b110, 30'h4C, 32'hAAAA004C, 4'hF, 3'b000, 3'b100));
    tbl.push_back(v("a_drop4",       7'b0_000_000, 30'h4C, 30'h200, 3'b000, DB,
                    3'b000, 30'h4C, 32'hAAAA004C, 4'hF, 3'b000, 3'b100));
    tbl.push_back(idle("idle4",      7'b0_000_000, 30'h4C, 30'h200, 3'b000, DB));

    drive(7'b1_000_000, 30'h0, 30'h0, 3'b000, DB);
    repeat (2) @(posedge i_clk);
    #1;

    foreach (tbl[i]) begin
      drive(tbl[i].ctl, tbl[i].aa, tbl[i].ba, tbl[i].sl, tbl[i].sd);
      @(negedge i_clk);
      check_row(tbl[i]);
      next_cycle();
    end

    // Watchdog: slave never answers A, error in the 8th busy cycle, then ABORT
    drive(7'b0_110_000, 30'h50, 30'h0, 3'b000, DB);
    @(negedge i_clk);
    chkb("to_req_idle.wb_cyc", sl.cyc, 1'b0);
    next_cycle();
    for (int i = 1; i <= TIMEOUT; i++) begin
      drive((i == 1) ? 7'b0_110_000 : 7'b0_100_000, 30'h50, 30'h0, 3'b000, DB);
      @(negedge i_clk);
      chkb($sformatf("to_busy%0d.wb_cyc", i), sl.cyc, 1'b1);
      chkb($sformatf("to_busy%0d.a_err", i), ma.err, (i == TIMEOUT));
      chkb($sformatf("to_busy%0d.a_ack", i), ma.ack, 1'b0);
      next_cycle();
    end
    // Stray slave ack while aborting must not reach anyone
    drive(7'b0_100_000, 30'h50, 30'h0, 3'b010, DB);
    @(negedge i_clk);
    chkb("abort.wb_cyc", sl.cyc, 1'b0);
    chkb("abort.a_stall", ma.stall, 1'b1);
    chkb("abort.a_ack", ma.ack, 1'b0);
    chkb("abort.a_err", ma.err, 1'b0);
    chkb("abort.b_ack", mb.ack, 1'b0);
    next_cycle();
    // A drops cyc; B requests but ABORT must first return to IDLE
    drive(7'b0_000_110, 30'h50, 30'h300, 3'b000, DB);
    @(negedge i_clk);
    chkb("abort_drop.wb_cyc", sl.cyc, 1'b0);
    chkb("abort_drop.a_stall", ma.stall, 1'b1);
    next_cycle();
    @(negedge i_clk);
    chkb("post_abort_idle.wb_cyc", sl.cyc, 1'b0);
    chkb("post_abort_idle.b_stall", mb.stall, 1'b1);
    next_cycle();
    @(negedge i_clk);
    chkb("post_abort_gnt_b.wb_cyc", sl.cyc, 1'b1);
    chkw("post_abort_gnt_b.wb_addr", 32'(sl.addr), 32'h300);
    chkb("post_abort_gnt_b.b_stall", mb.stall, 1'b0);
    next_cycle();
    drive(7'b0_000_000, 30'h50, 30'h300, 3'b000, DB);
    @(negedge i_clk);
    chkb("b_drop5.wb_cyc", sl.cyc, 1'b0);
    next_cycle();

    // Reset in the middle of an A cycle; pointer returns to "last = B"
    drive(7'b0_110_000, 30'h60, 30'h0, 3'b000, DB);
    @(negedge i_clk);
    chkb("rst_seq_idle.wb_cyc", sl.cyc, 1'b0);
    next_cycle();
    drive(7'b1_110_000, 30'h60, 30'h0, 3'b000, DB);
    @(negedge i_clk);
    chkb("rst_seq_gnt_a.wb_cyc", sl.cyc, 1'b1);
    chkw("rst_seq_gnt_a.wb_addr", 32'(sl.addr), 32'h60);
    next_cycle();
    drive(7'b0_110_110, 30'h60, 30'h310, 3'b010, DB);
    @(negedge i_clk);
    chkb("after_rst.wb_cyc", sl.cyc, 1'b0);
    chkb("after_rst.a_stall", ma.stall, 1'b1);
    chkb("after_rst.b_stall", mb.stall, 1'b1);
    chkb("after_rst.a_ack", ma.ack, 1'b0);
    next_cycle();
    drive(7'b0_110_110, 30'h60, 30'h310, 3'b000, DB);
    @(negedge i_clk);
    chkb("after_rst_gnt.wb_cyc", sl.cyc, 1'b1);
    chkw("after_rst_gnt.wb_addr", 32'(sl.addr), 32'h60);
    chkb("after_rst_gnt.a_stall", ma.stall, 1'b0);
    chkb("after_rst_gnt.b_stall", mb.stall, 1'b1);
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
